// File: rtl/keypad_matrix_emu.sv
// 4x4 keypad matrix emulator: turns press/release commands into bouncing contacts
// and answers the scanner's active-low row drive with registered active-low columns.
module keypad_matrix_emu #(
  parameter int unsigned BOUNCE_EDGES = 6,
  parameter int unsigned BOUNCE_MIN   = 16,
  parameter logic [7:0]  LFSR_SEED    = 8'hA5
) (
  input  logic        clk,
  input  logic        RSTn,
  input  logic [3:0]  row,
  output logic [3:0]  col,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [3:0]  cmd_key,
  input  logic        cmd_press,
  output logic [15:0] contact,
  output logic [15:0] key_state,
  output logic        busy
);

  localparam logic [7:0]    SEED       = (LFSR_SEED == 8'h00) ? 8'h01 : LFSR_SEED;
  localparam int            EW         = (BOUNCE_EDGES < 2) ? 1 : $clog2(BOUNCE_EDGES + 1);
  localparam logic [EW-1:0] EDGES_INIT = EW'(BOUNCE_EDGES);
  localparam logic [8:0]    MIN_M1     = 9'(BOUNCE_MIN - 1);

  typedef enum logic [1:0] {IDLE, BOUNCE, SETTLE, DONE} state_t;

  state_t        state;
  logic [7:0]    lfsr;
  logic [3:0]    key;
  logic          target;
  logic [8:0]    timer;
  logic [EW-1:0] edges;
  logic [3:0]    col_next;
  logic [8:0]    interval_m1;
  logic          fb;

  // Taps x^8+x^6+x^5+x^4+1; a nonzero state can never shift into zero.
  assign fb = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];

  // Timer is loaded with interval-1 so the gap between edges is exactly the interval.
  assign interval_m1 = 9'(BOUNCE_MIN) + {3'b000, lfsr[5:0]} - 9'd1;

  // Wire-AND of every selected row: a closed contact pulls its column low.
  assign col_next = ~(({4{~row[0]}} & contact[3:0])   |
                      ({4{~row[1]}} & contact[7:4])   |
                      ({4{~row[2]}} & contact[11:8])  |
                      ({4{~row[3]}} & contact[15:12]));

  // NOTE: every register here is assigned with <= so all updates see the
  // pre-edge values; blocking assignments would create order-dependent logic.
  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      state     <= IDLE;
      lfsr      <= SEED;
      col       <= 4'hF;
      contact   <= '0;
      key_state <= '0;
      cmd_ready <= 1'b1;
      busy      <= 1'b0;
      key       <= '0;
      target    <= 1'b0;
      timer     <= '0;
      edges     <= '0;
    end else begin
      lfsr <= {lfsr[6:0], fb};
      col  <= col_next;
      unique case (state)
        IDLE: begin
          // A command that matches the settled state is a no-op.
          if (cmd_valid && cmd_ready && (cmd_press != key_state[cmd_key])) begin
            key              <= cmd_key;
            target           <= cmd_press;
            contact[cmd_key] <= cmd_press;
            timer            <= interval_m1;
            edges            <= EDGES_INIT;
            cmd_ready        <= 1'b0;
            busy             <= 1'b1;
            if (BOUNCE_EDGES == 0) begin
              key_state[cmd_key] <= cmd_press;
              state              <= DONE;
            end else begin
              state <= BOUNCE;
            end
          end
        end
        BOUNCE: begin
          if (timer == 9'd0) begin
            contact[key] <= ~contact[key];
            edges        <= edges - 1'b1;
            if (edges == EW'(1)) begin
              timer <= MIN_M1;
              state <= SETTLE;
            end else begin
              timer <= interval_m1;
            end
          end else begin
            timer <= timer - 1'b1;
          end
        end
        SETTLE: begin
          // key_state is visible during DONE, one cycle ahead of cmd_ready.
          if (timer == 9'd0) begin
            key_state[key] <= target;
            state          <= DONE;
          end else begin
            timer <= timer - 1'b1;
          end
        end
        DONE: begin
          cmd_ready <= 1'b1;
          busy      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/keypad_matrix_emu.md
# keypad_matrix_emu

Emulates a 4x4 mechanical keypad matrix, including contact bounce, for closed-loop test of the keypad scan, debounce and decode chain. It watches the active-low row drive coming from the scanner and returns active-low column levels that reflect which emulated contacts are closed. Key presses and releases arrive as single commands on a valid/ready port. A pseudo-random bounce sequence is generated on every contact change. The block sits on the pin side of the scanner, either in the testbench or in a self-test build, and replaces the physical keypad.

## Interface
- BOUNCE_EDGES, 6: number of extra contact toggles after the first edge of each change. Must be even; 0 gives a clean single edge.
- BOUNCE_MIN, 16: minimum number of cycles between bounce toggles (1..255).
- LFSR_SEED, 8'hA5: bounce-interval LFSR seed. A value of 0 is replaced by 8'h01.

Ports (clock and reset first):
- clk  in  1  system clock; the only clock.
- RSTn  in  1  reset, asynchronous and active-low.
- row  in  4  scanner row drive, active-low; row[i]=0 selects row i.
- col  out  4  column return, active-low, registered.
- cmd_valid  in  1  a command is presented.
- cmd_ready  out  1  the block can accept a command; high only in IDLE.
- cmd_key  in  4  key index = row_idx*4 + col_idx.
- cmd_press  in  1  1 = close the contact, 0 = open it.
- contact  out  16  raw emulated contact state, including bounce; 1 = closed.
- key_state  out  16  settled (commanded) state; updates when a sequence completes.
- busy  out  1  a bounce sequence is in progress.

## Operation
- Column model: col[j] is 0 when there is any i with row[i]=0 and contact[i*4+j]=1; otherwise col[j] is 1. If more than one row is low at once, their columns are wire-AND combined. If all rows are high, col is 4'hF.
- LFSR: 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1. It advances every cycle after reset and never holds 0. Bounce interval = BOUNCE_MIN + lfsr[5:0], sampled when each interval is loaded.
- FSM states:
  - IDLE: cmd_ready=1, busy=0. A command is accepted on clk when cmd_valid & cmd_ready.
  - No-op: if cmd_press equals key_state[cmd_key], the block stays in IDLE. Nothing changes and cmd_ready stays 1.
  - Otherwise: contact[k] takes the target value in the cycle after acceptance (the first edge). The edge counter loads BOUNCE_EDGES and the timer loads an interval, then the FSM goes to BOUNCE. If BOUNCE_EDGES=0, the FSM goes directly to DONE.
  - BOUNCE: the timer counts down. At 0, contact[k] toggles, the counter decrements and a new interval is loaded. When the counter reaches 0, contact[k] equals the target and the FSM goes to SETTLE.
  - SETTLE: holds for BOUNCE_MIN cycles, then goes to DONE.
  - DONE: key_state[k] is set to the target, then the FSM returns to IDLE after one cycle.
- Only one key changes at a time. The contacts of other keys never change during a sequence.
- cmd_valid while busy is ignored; the command is not queued. Changing cmd_* while cmd_valid is high and cmd_ready is low is legal.

## Timing
- Reset values: col=4'hF, contact=0, key_state=0, busy=0, cmd_ready=1, FSM=IDLE, lfsr=LFSR_SEED.
- Reset asserted mid-sequence aborts the sequence. All contacts open and the block is ready in the first cycle after RSTn rises.
- col latency: exactly 1 clk from a row or contact change to col.
- Command latency: the first edge appears 1 cycle after acceptance. Total sequence length = 1 + sum(BOUNCE_EDGES intervals) + BOUNCE_MIN + 1 (DONE) cycles. cmd_ready returns high on the cycle after DONE.
- key_state changes exactly one cycle before cmd_ready returns.
- Counter widths: the interval timer is 9 bits, enough for a maximum of 255+63. The edge counter is sized to hold BOUNCE_EDGES.

## Test plan
- Reset, then row=4'b1110 with no commands -> col=4'hF, contact=0, cmd_ready=1.
- Press key 6 (row 1, col 2) with BOUNCE_EDGES=6 and row held at 4'b1101:
  - col[2] toggles exactly 7 times, each gap ≥ BOUNCE_MIN, then stays 0.
  - key_state=16'h0040 and cmd_ready returns high.
- Release key 6 -> 7 toggles ending with contact=0, col=4'hF, key_state=0. Then press key 6 twice in a row -> the second command is a no-op: no toggles, cmd_ready stays 1.
- Drive cmd_valid with key 3 while busy on key 6 -> key 3 contact never changes and is not applied later.
- Assert RSTn low mid-bounce on key 15, then release -> contact=0, key_state=0, col=4'hF and cmd_ready=1 on the first cycle after release.
- Full loop with the scan/debounce/decode chain: press key 9 with default parameters -> the decoded value is exactly 4'd9, reported once. Also check with BOUNCE_EDGES=0 -> the decoded value is still 9.
